// File: rtl/uart_rx.sv
// UART receiver: MSB-first frames with 8/9 data bits and 1/2 stop bits, run-time bit period,
// and a valid/ack holding register with sticky overrun and per-word framing error.
module uart_rx #(
    parameter int DIV_W       = 16,
    parameter int SYNC_STAGES = 2
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             rx_in,
    input  logic [DIV_W-1:0] br_div,
    input  logic             word,
    input  logic             stop,
    input  logic             enable,
    output logic [8:0]       data_out,
    output logic             valid,
    input  logic             ack,
    output logic             frame_err,
    output logic             overrun,
    output logic             busy
);

    typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_t;

    state_t                 state;
    logic [SYNC_STAGES-1:0] sync;
    logic                   rx_s;
    logic                   rx_prev;
    logic                   fall;
    logic [DIV_W-1:0]       div_q;
    logic [DIV_W-1:0]       cyc;
    logic [DIV_W-1:0]       half_last;
    logic [DIV_W-1:0]       bit_last;
    logic                   word_q;
    logic                   stop_q;
    logic                   scnt;
    logic                   ferr;
    logic [3:0]             bcnt;
    logic [8:0]             sh;

    assign rx_s      = sync[SYNC_STAGES-1];
    assign fall      = rx_prev & ~rx_s;
    assign half_last = (div_q >> 1) - 1'b1;
    assign bit_last  = div_q - 1'b1;

    // Synchroniser and edge history preset to the idle line level.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            sync    <= '1;
            rx_prev <= 1'b1;
        end else begin
            sync    <= {sync[SYNC_STAGES-2:0], rx_in};
            rx_prev <= rx_s;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state     <= IDLE;
            data_out  <= '0;
            valid     <= 1'b0;
            frame_err <= 1'b0;
            overrun   <= 1'b0;
            busy      <= 1'b0;
            div_q     <= '0;
            cyc       <= '0;
            word_q    <= 1'b0;
            stop_q    <= 1'b0;
            scnt      <= 1'b0;
            ferr      <= 1'b0;
            bcnt      <= '0;
            sh        <= '0;
        end else begin
            // A commit later in this block overrides the ack clear, so the new word stays valid.
            if (ack && valid) begin
                valid   <= 1'b0;
                overrun <= 1'b0;
            end

            if (state != IDLE && !enable) begin
                state <= IDLE;
                busy  <= 1'b0;
            end else begin
                case (state)
                    IDLE: begin
                        if (enable && fall) begin
                            state  <= START;
                            busy   <= 1'b1;
                            cyc    <= '0;
                            div_q  <= br_div;
                            word_q <= word;
                            stop_q <= stop;
                            ferr   <= 1'b0;
                        end
                    end
                    START: begin
                        if (cyc == half_last) begin
                            if (rx_s) begin
                                state <= IDLE;
                                busy  <= 1'b0;
                            end else begin
                                state <= DATA;
                                cyc   <= '0;
                                bcnt  <= word_q ? 4'd8 : 4'd7;
                                sh    <= '0;
                            end
                        end else begin
                            cyc <= cyc + 1'b1;
                        end
                    end
                    DATA: begin
                        if (cyc == bit_last) begin
                            sh  <= {sh[7:0], rx_s};
                            cyc <= '0;
                            if (bcnt == 4'd0) begin
                                state <= STOP;
                                scnt  <= stop_q;
                            end else begin
                                bcnt <= bcnt - 1'b1;
                            end
                        end else begin
                            cyc <= cyc + 1'b1;
                        end
                    end
                    STOP: begin
                        if (cyc == bit_last) begin
                            if (scnt) begin
                                scnt <= 1'b0;
                                cyc  <= '0;
                                ferr <= ferr | ~rx_s;
                            end else begin
                                data_out  <= word_q ? sh : {1'b0, sh[7:0]};
                                frame_err <= ferr | ~rx_s;
                                ferr      <= 1'b0;
                                valid     <= 1'b1;
                                if (valid && !ack)
                                    overrun <= 1'b1;
                                state     <= IDLE;
                                busy      <= 1'b0;
                            end
                        end else begin
                            cyc <= cyc + 1'b1;
                        end
                    end
                    default: begin
                        state <= IDLE;
                        busy  <= 1'b0;
                    end
                endcase
            end
        end
    end

endmodule

// File: tb/tb_uart_rx.sv
// Directed bench for uart_rx: frames are driven bit by bit, expected words go into a scoreboard
// queue and are popped when the receiver presents valid.
module tb_uart_rx;

    logic        clk = 1'b0;
    logic        rst;
    logic        rx_in;
    logic [15:0] br_div;
    logic        word;
    logic        stop;
    logic        enable;
    logic [8:0]  data_out;
    logic        valid;
    logic        ack;
    logic        frame_err;
    logic        overrun;
    logic        busy;

    typedef struct packed {
        logic [8:0] data;
        logic       ferr;
    } exp_t;

    exp_t sb[$];
    int   nvec = 0;
    int   nfail = 0;
    int   ncyc;
    int   fall_at;
    int   vrise_at;
    logic valid_at_fall;
    logic busy_prev;
    logic valid_prev;

    uart_rx #(.DIV_W(16), .SYNC_STAGES(2)) dut (
        .clk(clk), .rst(rst), .rx_in(rx_in), .br_div(br_div), .word(word), .stop(stop),
        .enable(enable), .data_out(data_out), .valid(valid), .ack(ack),
        .frame_err(frame_err), .overrun(overrun), .busy(busy)
    );

    always #5 clk = ~clk;

    task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        nvec++;
        assert (obs === exp)
        else begin
            nfail++;
            $error("[TB] FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // One negedge step; tracks when busy falls and when valid rises, relative to the frame start.
    task automatic tick();
        @(negedge clk);
        ncyc++;
        if (fall_at < 0 && busy_prev && !busy) begin
            fall_at       = ncyc;
            valid_at_fall = valid;
        end
        if (vrise_at < 0 && !valid_prev && valid)
            vrise_at = ncyc;
        busy_prev  = busy;
        valid_prev = valid;
    endtask

    task automatic startMeasure();
        ncyc       = 0;
        fall_at    = -1;
        vrise_at   = -1;
        busy_prev  = busy;
        valid_prev = valid;
    endtask

    task automatic driveBit(input logic b);
        rx_in = b;
        repeat (16) tick();
    endtask

    task automatic applyStimulus(input logic [8:0] d, input logic nine, input logic two_stop,
                                 input logic bad_stop);
        exp_t e;
        word   = nine;
        stop   = two_stop;
        br_div = 16'd16;
        e.data = nine ? d : {1'b0, d[7:0]};
        e.ferr = bad_stop;
        sb.push_back(e);
        startMeasure();
        driveBit(1'b0);
        for (int i = (nine ? 8 : 7); i >= 0; i--)
            driveBit(d[i]);
        driveBit(~bad_stop);
        if (two_stop)
            driveBit(1'b1);
        rx_in = 1'b1;
    endtask

    task automatic expectWord(input string tag, input logic exp_ovr);
        exp_t e;
        for (int i = 0; i < 2000 && !valid; i++)
            tick();
        checkOutput({tag, "_valid"}, valid, 1);
        while (sb.size() > 1)
            void'(sb.pop_front());
        checkOutput({tag, "_sb"}, sb.size(), 1);
        if (sb.size() > 0) begin
            e = sb.pop_front();
            checkOutput({tag, "_data"}, data_out, e.data);
            checkOutput({tag, "_ferr"}, frame_err, e.ferr);
        end
        checkOutput({tag, "_ovr"}, overrun, exp_ovr);
    endtask

    task automatic pulseAck();
        ack = 1'b1;
        tick();
        ack = 1'b0;
    endtask

    initial begin
        rst    = 1'b0;
        rx_in  = 1'b1;
        br_div = 16'd16;
        word   = 1'b0;
        stop   = 1'b0;
        enable = 1'b1;
        ack    = 1'b0;
        startMeasure();
        repeat (3) tick();
        checkOutput("rst_data", data_out, 0);
        checkOutput("rst_valid", valid, 0);
        checkOutput("rst_ferr", frame_err, 0);
        checkOutput("rst_ovr", overrun, 0);
        checkOutput("rst_busy", busy, 0);
        rst = 1'b1;
        repeat (5) tick();

        // Basic 8-bit frame, then ack.
        applyStimulus(9'h0A5, 1'b0, 1'b0, 1'b0);
        checkOutput("t1_fall_at", fall_at, 155);
        checkOutput("t1_vrise_at", vrise_at, 155);
        expectWord("t1", 1'b0);
        pulseAck();
        checkOutput("t1_ack_valid", valid, 0);

        // 9-bit frame with two stop bits; valid only after the second stop sample.
        applyStimulus(9'h1C3, 1'b1, 1'b1, 1'b0);
        checkOutput("t2_fall_at", fall_at, 187);
        checkOutput("t2_vrise_at", vrise_at, 187);
        checkOutput("t2_valid_at_fall", valid_at_fall, 1);
        expectWord("t2", 1'b0);
        pulseAck();

        // Low stop bit, then a good frame clears frame_err.
        applyStimulus(9'h03C, 1'b0, 1'b0, 1'b1);
        expectWord("t3a", 1'b0);
        pulseAck();
        applyStimulus(9'h055, 1'b0, 1'b0, 1'b0);
        expectWord("t3b", 1'b0);
        pulseAck();
        repeat (20) tick();

        // Short glitch is rejected as a false start at the half-bit check.
        startMeasure();
        rx_in = 1'b0;
        repeat (4) tick();
        checkOutput("t4_busy", busy, 1);
        rx_in = 1'b1;
        repeat (16) tick();
        checkOutput("t4_fall_at", fall_at, 11);
        checkOutput("t4_valid", valid, 0);

        // Back-to-back frames without ack: newest word wins, overrun set.
        applyStimulus(9'h011, 1'b0, 1'b0, 1'b0);
        applyStimulus(9'h022, 1'b0, 1'b0, 1'b0);
        expectWord("t5", 1'b1);
        pulseAck();
        checkOutput("t5_ack_valid", valid, 0);
        checkOutput("t5_ack_ovr", overrun, 0);

        // Asynchronous reset in the middle of a data bit with outputs loaded.
        applyStimulus(9'h077, 1'b0, 1'b0, 1'b0);
        applyStimulus(9'h044, 1'b0, 1'b0, 1'b0);
        expectWord("t6pre", 1'b1);
        rx_in = 1'b0;
        repeat (40) tick();
        checkOutput("t6_busy_pre", busy, 1);
        rst = 1'b0;
        #1;
        checkOutput("t6_rst_data", data_out, 0);
        checkOutput("t6_rst_valid", valid, 0);
        checkOutput("t6_rst_ovr", overrun, 0);
        checkOutput("t6_rst_busy", busy, 0);
        rx_in = 1'b1;
        repeat (3) tick();
        rst = 1'b1;
        repeat (5) tick();

        // Disable mid-frame aborts without touching the held word.
        applyStimulus(9'h05A, 1'b0, 1'b0, 1'b0);
        expectWord("t6dis", 1'b0);
        rx_in = 1'b0;
        repeat (40) tick();
        enable = 1'b0;
        tick();
        checkOutput("t6_dis_busy", busy, 0);
        checkOutput("t6_dis_valid", valid, 1);
        checkOutput("t6_dis_data", data_out, 9'h05A);
        rx_in = 1'b1;
        repeat (5) tick();
        enable = 1'b1;
        repeat (5) tick();
        pulseAck();
        applyStimulus(9'h0F0, 1'b0, 1'b0, 1'b0);
        checkOutput("t6_f0_fall_at", fall_at, 155);
        expectWord("t6f0", 1'b0);

        $display("== %0d vectors applied, %0d miscompares ==", nvec, nfail);
        $finish;
    end

endmodule
